// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types and encodings for the ALU op sequencer
// Purpose: ALU control codes, MIPS-subset opcode/funct encodings, sequencer
//          FSM states and an immediate sign-extension helper.
// Ports:   none (package).
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b011,
    ALU_SLT = 3'b100,
    ALU_SLL = 3'b101,
    ALU_SRL = 3'b110
  } alu_ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } seq_state_t;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// rtl/alu_op_sequencer_if.sv - request, ALU and result signals of the sequencer
// Purpose: bundles the instruction request handshake, the ALU operand/result
//          wires and the result handshake.
// Ports:   master = sequencer side (drives in_ready, alu_in1/2, alu_ctrl, res_*),
//          slave  = environment side (drives in_valid, instr, rs/rt_val,
//                   alu_out, alu_zero, res_ready).
interface alu_op_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] alu_in1;
  logic [31:0] alu_in2;
  logic [2:0]  alu_ctrl;
  logic [31:0] alu_out;
  logic        alu_zero;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        res_is_branch;
  logic        res_taken;
  logic        res_illegal;

  modport master (
    input  in_valid, instr, rs_val, rt_val, alu_out, alu_zero, res_ready,
    output in_ready, alu_in1, alu_in2, alu_ctrl,
           res_valid, res_data, res_is_branch, res_taken, res_illegal
  );

  modport slave (
    output in_valid, instr, rs_val, rt_val, alu_out, alu_zero, res_ready,
    input  in_ready, alu_in1, alu_in2, alu_ctrl,
           res_valid, res_data, res_is_branch, res_taken, res_illegal
  );
endinterface

// File: rtl/alu_op_decode.sv
// rtl/alu_op_decode.sv - combinational MIPS-subset decoder to ALU operands
// Purpose: maps an instruction plus rs/rt values to ALU operands and control.
// Ports:   instr, rs_val, rt_val in; in1, in2, ctrl, is_branch, is_bne,
//          illegal out.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic [31:0] in1,
  output logic [31:0] in2,
  output alu_ctrl_t   ctrl,
  output logic        is_branch,
  output logic        is_bne,
  output logic        illegal
);

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [15:0] imm;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];
  assign shamt  = instr[10:6];
  assign imm    = instr[15:0];

  // Register specifier fields are resolved upstream; only their values arrive.
  logic unused_fields;
  assign unused_fields = ^instr[25:16];

  always_comb begin
    in1       = rs_val;
    in2       = rt_val;
    ctrl      = ALU_ADD;
    is_branch = 1'b0;
    is_bne    = 1'b0;
    illegal   = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_AND: ctrl = ALU_AND;
          FN_OR:  ctrl = ALU_OR;
          FN_ADD: ctrl = ALU_ADD;
          FN_SUB: ctrl = ALU_SUB;
          FN_SLT: ctrl = ALU_SLT;
          // Shifts operate on rt; the shift amount rides on operand 2.
          FN_SLL: begin ctrl = ALU_SLL; in1 = rt_val; in2 = {27'd0, shamt}; end
          FN_SRL: begin ctrl = ALU_SRL; in1 = rt_val; in2 = {27'd0, shamt}; end
          default: illegal = 1'b1;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW: begin ctrl = ALU_ADD; in2 = sext16(imm); end
      OP_SLTI: begin ctrl = ALU_SLT; in2 = sext16(imm); end
      OP_ANDI: begin ctrl = ALU_AND; in2 = {16'd0, imm}; end
      OP_ORI:  begin ctrl = ALU_OR;  in2 = {16'd0, imm}; end
      OP_BEQ:  begin ctrl = ALU_SUB; is_branch = 1'b1; end
      OP_BNE:  begin ctrl = ALU_SUB; is_branch = 1'b1; is_bne = 1'b1; end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - ALU initiator: decode, wait ALU latency, return result
// Purpose: accepts one instruction, drives the ALU for ALU_LATENCY cycles,
//          captures result/zero and presents it over a valid/ready handshake.
// Ports:   clk, reset (async, active high); bus (alu_op_sequencer_if.master);
//          op_count[31:0], illegal_count[15:0] only when ALU_SEQ_PERF_EN is defined.
// Config:  `define ALU_SEQ_PERF_EN adds the handshake/illegal counters.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned ALU_LATENCY = 1
) (
  input logic                clk,
  input logic                reset,
  alu_op_sequencer_if.master bus
`ifdef ALU_SEQ_PERF_EN
  ,
  output logic [31:0]        op_count,
  output logic [15:0]        illegal_count
`endif
);

  localparam logic [3:0] CNT_LOAD = 4'(ALU_LATENCY - 1);

  seq_state_t  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] in1_q, in1_d, in2_q, in2_d;
  alu_ctrl_t   ctrl_q, ctrl_d;
  logic        is_bne_q, is_bne_d;
  logic        res_is_branch_q, res_is_branch_d;
  logic [31:0] res_data_q, res_data_d;
  logic        res_taken_q, res_taken_d;
  logic        res_illegal_q, res_illegal_d;

  logic [31:0] dec_in1, dec_in2;
  alu_ctrl_t   dec_ctrl;
  logic        dec_is_branch, dec_is_bne, dec_illegal;

  alu_op_decode u_decode (
    .instr     (bus.instr),
    .rs_val    (bus.rs_val),
    .rt_val    (bus.rt_val),
    .in1       (dec_in1),
    .in2       (dec_in2),
    .ctrl      (dec_ctrl),
    .is_branch (dec_is_branch),
    .is_bne    (dec_is_bne),
    .illegal   (dec_illegal)
  );

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.in_valid) state_d = dec_illegal ? RESP : EXEC;
      EXEC: if (cnt_q == 4'd0) state_d = RESP;
      RESP: if (bus.res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs; in_ready is masked by reset so it reads 0 while reset is held.
  always_comb begin
    bus.in_ready  = (state_q == IDLE) && !reset;
    bus.res_valid = (state_q == RESP);
  end

  // Operand and result datapath
  always_comb begin
    cnt_d           = cnt_q;
    in1_d           = in1_q;
    in2_d           = in2_q;
    ctrl_d          = ctrl_q;
    is_bne_d        = is_bne_q;
    res_is_branch_d = res_is_branch_q;
    res_data_d      = res_data_q;
    res_taken_d     = res_taken_q;
    res_illegal_d   = res_illegal_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          res_illegal_d   = dec_illegal;
          res_is_branch_d = dec_is_branch;
          is_bne_d        = dec_is_bne;
          res_taken_d     = 1'b0;
          if (dec_illegal) begin
            res_data_d = '0;
          end else begin
            // ALU operands only change for ops that actually use the ALU.
            in1_d  = dec_in1;
            in2_d  = dec_in2;
            ctrl_d = dec_ctrl;
            cnt_d  = CNT_LOAD;
          end
        end
      end
      EXEC: begin
        if (cnt_q == 4'd0) begin
          res_data_d  = bus.alu_out;
          res_taken_d = res_is_branch_q & (is_bne_q ? ~bus.alu_zero : bus.alu_zero);
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q           <= '0;
      in1_q           <= '0;
      in2_q           <= '0;
      ctrl_q          <= ALU_AND;
      is_bne_q        <= 1'b0;
      res_is_branch_q <= 1'b0;
      res_data_q      <= '0;
      res_taken_q     <= 1'b0;
      res_illegal_q   <= 1'b0;
    end else begin
      cnt_q           <= cnt_d;
      in1_q           <= in1_d;
      in2_q           <= in2_d;
      ctrl_q          <= ctrl_d;
      is_bne_q        <= is_bne_d;
      res_is_branch_q <= res_is_branch_d;
      res_data_q      <= res_data_d;
      res_taken_q     <= res_taken_d;
      res_illegal_q   <= res_illegal_d;
    end
  end

  assign bus.alu_in1       = in1_q;
  assign bus.alu_in2       = in2_q;
  assign bus.alu_ctrl      = ctrl_q;
  assign bus.res_data      = res_data_q;
  assign bus.res_is_branch = res_is_branch_q;
  assign bus.res_taken     = res_taken_q;
  assign bus.res_illegal   = res_illegal_q;

`ifdef ALU_SEQ_PERF_EN
  logic [31:0] op_count_q, op_count_d;
  logic [15:0] illegal_count_q, illegal_count_d;
  logic        handshake;

  assign handshake = (state_q == RESP) && bus.res_ready;

  always_comb begin
    op_count_d      = op_count_q + {31'd0, handshake};
    illegal_count_d = illegal_count_q + {15'd0, handshake & res_illegal_q};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_count_q      <= '0;
      illegal_count_q <= '0;
    end else begin
      op_count_q      <= op_count_d;
      illegal_count_q <= illegal_count_d;
    end
  end

  assign op_count      = op_count_q;
  assign illegal_count = illegal_count_q;
`endif

endmodule
